// File: rtl/trng_word_reader.sv
// trng_word_reader: read side of the TRNG conditioned-output path.
// Two ping-pong slots buffer 256-bit conditioned blocks. They are served MSB-first
// as WORD_W-bit words. A slot is zeroized when its last word is consumed, so no
// random word is ever delivered twice.
// Optional build macro: TRNG_REPEAT_CHECK_EN drops a block equal to the previous
// accepted block and sets the sticky rpt_err flag.
module trng_word_reader #(
    parameter  int BLOCK_W = 256,
    parameter  int WORD_W  = 32,
    localparam int NW      = BLOCK_W / WORD_W,
    localparam int WIDX_W  = $clog2(NW),
    localparam int LVL_W   = $clog2(2 * NW + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] blk_data,
    input  logic               blk_valid,
    output logic               blk_ready,
    output logic [WORD_W-1:0]  rnd_data,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    input  logic               flush,
    output logic [LVL_W-1:0]   level,
    output logic               rpt_err
);

    logic [BLOCK_W-1:0] slot_q [2];
    logic [BLOCK_W-1:0] slot_d [2];
    logic [1:0]         slot_full_q, slot_full_d;
    logic               wp_q, wp_d;
    logic               rp_q, rp_d;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               accept, drain, store, last_word;
    logic [WORD_W-1:0]  word_sel;

    // Handshakes depend only on registered occupancy; flush masks both sides
    assign blk_ready = ~flush & ~slot_full_q[wp_q];
    assign rnd_valid = ~flush & slot_full_q[rp_q];
    assign accept    = blk_valid & blk_ready;
    assign drain     = rnd_valid & rnd_ready;
    assign last_word = (widx_q == WIDX_W'(NW - 1));
    assign level     = level_q;
    assign rnd_data  = rnd_valid ? word_sel : '0;

    // Select word widx of the read slot, word 0 being the most significant
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NW; i++) begin
            if (widx_q == WIDX_W'(i)) begin
                word_sel = slot_q[rp_q][BLOCK_W-1-i*WORD_W -: WORD_W];
            end
        end
    end

`ifdef TRNG_REPEAT_CHECK_EN
    logic [BLOCK_W-1:0] last_q, last_d;
    logic               last_vld_q, last_vld_d;
    logic               rpt_err_q, rpt_err_d;
    logic               is_repeat;

    assign is_repeat = last_vld_q & (blk_data == last_q);
    assign store     = accept & ~is_repeat;
    assign rpt_err   = rpt_err_q;

    // Remember every accepted block; a repeat is consumed but not stored
    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        rpt_err_d  = rpt_err_q;
        if (accept) begin
            last_d     = blk_data;
            last_vld_d = 1'b1;
            if (is_repeat) rpt_err_d = 1'b1;
        end
    end

    // Compare state survives flush; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
            rpt_err_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            rpt_err_q  <= rpt_err_d;
        end
    end
`else
    assign store   = accept;
    assign rpt_err = 1'b0;
`endif

    // Next-state for slots, pointers, word index and level; flush overrides all
    always_comb begin
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        widx_d      = widx_q;
        level_d     = level_q;
        if (flush) begin
            slot_d[0]   = '0;
            slot_d[1]   = '0;
            slot_full_d = '0;
            wp_d        = 1'b0;
            rp_d        = 1'b0;
            widx_d      = '0;
            level_d     = '0;
        end else begin
            // wp != rp whenever store and drain coincide, so the writes never collide
            if (store) begin
                slot_d[wp_q]      = blk_data;
                slot_full_d[wp_q] = 1'b1;
                wp_d              = ~wp_q;
            end
            if (drain) begin
                if (last_word) begin
                    slot_d[rp_q]      = '0;
                    slot_full_d[rp_q] = 1'b0;
                    rp_d              = ~rp_q;
                    widx_d            = '0;
                end else begin
                    widx_d = widx_q + WIDX_W'(1);
                end
            end
            level_d = level_q + (store ? LVL_W'(NW) : '0) - (drain ? LVL_W'(1) : '0);
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q[0]   <= '0;
            slot_q[1]   <= '0;
            slot_full_q <= '0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            widx_q      <= '0;
            level_q     <= '0;
        end else begin
            slot_q[0]   <= slot_d[0];
            slot_q[1]   <= slot_d[1];
            slot_full_q <= slot_full_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            widx_q      <= widx_d;
            level_q     <= level_d;
        end
    end

endmodule
